// File: rtl/soc_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Read data returns one cycle after issue and is steered to the requester that issued it.
module soc_ram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  m0_grants,
    output logic [CNT_W-1:0]  m1_grants
);

    logic              w_m0_req;
    logic              w_m1_req;
    logic              w_issue;
    logic              w_win;
    logic              w_win_wr;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;

    logic              r_rr_last;
    logic              r_rd_pend;
    logic              r_rd_id;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_writedata;
    logic [CNT_W-1:0]  r_m0_cnt;
    logic [CNT_W-1:0]  r_m1_cnt;

    assign w_m0_req = m0_read | m0_write;
    assign w_m1_req = m1_read | m1_write;

    always_comb begin
        w_win = 1'b0;
        if (w_m0_req && w_m1_req) begin
            w_win = ~r_rr_last;
        end else if (w_m1_req) begin
            w_win = 1'b1;
        end
        w_issue    = reset_n & (w_m0_req | w_m1_req);
        // A write takes priority when read and write are both asserted.
        w_win_wr   = w_win ? m1_write : m0_write;
        w_win_addr = w_win ? m1_address : m0_address;
        w_win_data = w_win ? m1_writedata : m0_writedata;
    end

    assign m0_waitrequest   = ~(w_issue & ~w_win);
    assign m1_waitrequest   = ~(w_issue & w_win);

    assign mem_chipselect   = w_issue;
    assign mem_write        = w_issue & w_win_wr;
    assign mem_address      = w_issue ? w_win_addr : r_mem_address;
    assign mem_writedata    = w_issue ? w_win_data : r_mem_writedata;
    assign mem_clken        = reset_n;

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    // Gating with reset_n drops a read issued the cycle before reset.
    assign m0_readdatavalid = reset_n & r_rd_pend & ~r_rd_id;
    assign m1_readdatavalid = reset_n & r_rd_pend & r_rd_id;

    assign m0_grants        = r_m0_cnt;
    assign m1_grants        = r_m1_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_last       <= 1'b1;
            r_rd_pend       <= 1'b0;
            r_rd_id         <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
        end else begin
            r_rd_pend <= w_issue & ~w_win_wr;
            if (w_issue) begin
                r_rr_last       <= w_win;
                r_rd_id         <= w_win;
                r_mem_address   <= w_win_addr;
                r_mem_writedata <= w_win_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || cnt_clear) begin
            r_m0_cnt <= '0;
            r_m1_cnt <= '0;
        end else if (w_issue) begin
            if (!w_win && r_m0_cnt != '1) begin
                r_m0_cnt <= r_m0_cnt + 1'b1;
            end
            if (w_win && r_m1_cnt != '1) begin
                r_m1_cnt <= r_m1_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// Directed bench for soc_ram_arbiter with a behavioural 1-cycle-latency RAM model.
module tb_soc_ram_arbiter;

    logic        clk;
    logic        reset_n;
    logic [15:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [7:0]  m0_writedata;
    logic        m0_waitrequest;
    logic [7:0]  m0_readdata;
    logic        m0_readdatavalid;
    logic [15:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [7:0]  m1_writedata;
    logic        m1_waitrequest;
    logic [7:0]  m1_readdata;
    logic        m1_readdatavalid;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [7:0]  mem_writedata;
    logic        mem_clken;
    logic [7:0]  mem_readdata;
    logic        cnt_clear;
    logic [3:0]  m0_grants;
    logic [3:0]  m1_grants;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram [0:65535];

    soc_ram_arbiter #(
        .ADDR_W(16),
        .DATA_W(8),
        .CNT_W (4)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m0_address      (m0_address),
        .m0_read         (m0_read),
        .m0_write        (m0_write),
        .m0_writedata    (m0_writedata),
        .m0_waitrequest  (m0_waitrequest),
        .m0_readdata     (m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address      (m1_address),
        .m1_read         (m1_read),
        .m1_write        (m1_write),
        .m1_writedata    (m1_writedata),
        .m1_waitrequest  (m1_waitrequest),
        .m1_readdata     (m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address     (mem_address),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata),
        .cnt_clear       (cnt_clear),
        .m0_grants       (m0_grants),
        .m1_grants       (m1_grants)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) ram[mem_address] <= mem_writedata;
            else           mem_readdata     <= ram[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0;
        m1_read = 1'b0; m1_write = 1'b0;
        cnt_clear = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        ram[16'h0010] = 8'hA5;
        ram[16'h0020] = 8'h3C;
        mem_readdata  = 8'h00;
        m0_address = 16'h0; m0_writedata = 8'h0;
        m1_address = 16'h0; m1_writedata = 8'h0;
        idle();
        reset_n = 1'b0;
        m0_read = 1'b1;

        // Outputs while in reset, even with a live request.
        @(negedge clk);
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_m1_wait", m1_waitrequest, 1);
        check("rst_cs", mem_chipselect, 0);
        check("rst_clken", mem_clken, 0);
        check("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        check("rst_grants", {m0_grants, m1_grants}, 0);
        tick();
        reset_n = 1'b1;
        idle();
        check("idle_m0_wait", m0_waitrequest, 1);

        // Single m0 read of 0x0010.
        m0_read = 1'b1; m0_address = 16'h0010;
        @(negedge clk);
        check("rd_m0_wait", m0_waitrequest, 0);
        check("rd_cs", mem_chipselect, 1);
        check("rd_we", mem_write, 0);
        check("rd_addr", mem_address, 16'h0010);
        check("rd_clken", mem_clken, 1);
        tick();
        idle();
        @(negedge clk);
        check("rd_m0_rdv", m0_readdatavalid, 1);
        check("rd_m0_data", m0_readdata, 8'hA5);
        check("rd_m1_rdv", m1_readdatavalid, 0);
        check("rd_hold_addr", mem_address, 16'h0010);
        check("rd_m0_grants", m0_grants, 1);

        // Both read continuously: strict alternation starting with m0.
        do_reset();
        m0_read = 1'b1; m0_address = 16'h0010;
        m1_read = 1'b1; m1_address = 16'h0020;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_m0_wait", m0_waitrequest, (i % 2 == 0) ? 0 : 1);
            check("rr_m1_wait", m1_waitrequest, (i % 2 == 0) ? 1 : 0);
            if (i > 0) begin
                check("rr_m0_rdv", m0_readdatavalid, (i % 2 == 1) ? 1 : 0);
                check("rr_m1_rdv", m1_readdatavalid, (i % 2 == 0) ? 1 : 0);
                check("rr_data", mem_readdata, (i % 2 == 1) ? 8'hA5 : 8'h3C);
            end
            tick();
        end
        idle();
        @(negedge clk);
        check("rr_last_m1_rdv", m1_readdatavalid, 1);
        check("rr_last_m1_data", m1_readdata, 8'h3C);
        check("rr_m0_grants", m0_grants, 3);
        check("rr_m1_grants", m1_grants, 3);

        // m1 write then m0 read of the same address.
        tick();
        m1_write = 1'b1; m1_address = 16'h1234; m1_writedata = 8'h5A;
        @(negedge clk);
        check("wr_m1_wait", m1_waitrequest, 0);
        check("wr_we", mem_write, 1);
        check("wr_data", mem_writedata, 8'h5A);
        tick();
        idle();
        m0_read = 1'b1; m0_address = 16'h1234;
        @(negedge clk);
        check("wr_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        check("wrrd_m0_wait", m0_waitrequest, 0);
        tick();
        idle();
        @(negedge clk);
        check("wrrd_m0_rdv", m0_readdatavalid, 1);
        check("wrrd_m0_data", m0_readdata, 8'h5A);
        check("wrrd_m1_rdv", m1_readdatavalid, 0);

        // Read then read+write: write wins, pending return undisturbed.
        tick();
        m0_read = 1'b1; m0_address = 16'h0010;
        tick();
        m0_write = 1'b1; m0_address = 16'h0001; m0_writedata = 8'h77;
        @(negedge clk);
        check("rw_we", mem_write, 1);
        check("rw_addr", mem_address, 16'h0001);
        check("rw_prev_rdv", m0_readdatavalid, 1);
        check("rw_prev_data", m0_readdata, 8'hA5);
        tick();
        m0_write = 1'b0;
        @(negedge clk);
        check("rw_no_rdv", m0_readdatavalid, 0);
        tick();
        idle();
        @(negedge clk);
        check("rw_rb_rdv", m0_readdatavalid, 1);
        check("rw_rb_data", m0_readdata, 8'h77);

        // Read pending when reset asserts is discarded.
        tick();
        m0_read = 1'b1; m0_address = 16'h0010;
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        check("rr_drop_rdv", m0_readdatavalid, 0);
        check("rr_drop_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        check("rr_drop_cs", mem_chipselect, 0);
        tick();
        @(negedge clk);
        check("rr_drop_grants", {m0_grants, m1_grants}, 0);
        tick();
        reset_n = 1'b1;
        idle();
        @(negedge clk);
        check("post_rst_rdv", m0_readdatavalid, 0);

        // Saturation and clear overriding a concurrent grant.
        tick();
        m0_write = 1'b1; m0_address = 16'h0100; m0_writedata = 8'h11;
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        check("sat_m0_grants", m0_grants, 15);
        tick();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        @(negedge clk);
        check("clr_m0_grants", m0_grants, 0);
        tick();
        idle();
        @(negedge clk);
        check("clr_resume", m0_grants, 1);
        check("clr_m1_grants", m1_grants, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
